and_sinina_seq: RTL

//  Sequencer/arbiter that shares one and_sinina gadget instance between N_REQ requesters.

---
 rtl/and_sinina_seq.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/and_sinina_seq.sv
// and_sinina_seq: round-robin sequencer sharing one masked-AND gadget among
// N_REQ requesters. Issues at most one operation per cycle, consumes one fresh
// randomness word per issue, tracks in-flight operations with a tag pipeline
// matched to the gadget latency, and routes each result back to its requester.
module and_sinina_seq #(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned W     = 3,
    parameter int unsigned LAT   = 3,
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ*W-1:0]   req_a_0,
    input  logic [N_REQ*W-1:0]   req_a_1,
    input  logic [N_REQ*W-1:0]   req_b_0,
    input  logic [N_REQ*W-1:0]   req_b_1,
    input  logic                 rnd_valid,
    input  logic [1:0]           rnd_data,
    output logic                 rnd_ready,
    output logic [W-1:0]         g_a_0,
    output logic [W-1:0]         g_a_1,
    output logic [W-1:0]         g_b_0,
    output logic [W-1:0]         g_b_1,
    output logic [1:0]           g_r,
    input  logic [W-1:0]         g_c_0,
    input  logic [W-1:0]         g_c_1,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [W-1:0]         rsp_c_0,
    output logic [W-1:0]         rsp_c_1,
    output logic                 busy,
    output logic [CNT_W-1:0]     ops_cnt
);

    localparam int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned INF_W = $clog2(LAT + 2);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   ptr_nxt;

    logic              grant_ok;
    logic              grant_found;
    logic [ID_W-1:0]   grant_id;
    logic [N_REQ-1:0]  grant_vec;

    logic [W-1:0]      a0_arr [0:N_REQ-1];
    logic [W-1:0]      a1_arr [0:N_REQ-1];
    logic [W-1:0]      b0_arr [0:N_REQ-1];
    logic [W-1:0]      b1_arr [0:N_REQ-1];

    logic [LAT:0]      tag_v;
    logic [ID_W-1:0]   tag_id [0:LAT];
    logic [INF_W-1:0]  inflight;
    logic [N_REQ-1:0]  rsp_vec;

    // Unpack the flat per-requester share buses into arrays indexed by requester id.
    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign a0_arr[g] = req_a_0[g*W +: W];
        assign a1_arr[g] = req_a_1[g*W +: W];
        assign b0_arr[g] = req_b_0[g*W +: W];
        assign b1_arr[g] = req_b_1[g*W +: W];
    end

    // Grant is only possible with fresh randomness and outside DRAIN; the
    // reset term keeps the handshakes quiet while reset is being sampled.
    assign grant_ok = !reset && en && rnd_valid && (|req_valid) && (state != ST_DRAIN);

    // Round-robin search starting at the pointer, wrapping modulo N_REQ.
    always_comb begin
        int unsigned idx;
        logic [ID_W-1:0] cand;
        grant_found = 1'b0;
        grant_id    = '0;
        idx         = 0;
        cand        = '0;
        if (grant_ok) begin
            for (int unsigned off = 0; off < N_REQ; off++) begin
                idx  = (32'(ptr) + off) % N_REQ;
                cand = ID_W'(idx);
                if (!grant_found && req_valid[cand]) begin
                    grant_found = 1'b1;
                    grant_id    = cand;
                end
            end
        end
    end

    // One-hot grant vector and next pointer (winner + 1, wrapped).
    always_comb begin
        grant_vec = '0;
        if (grant_found) begin
            grant_vec[grant_id] = 1'b1;
        end
        ptr_nxt = ID_W'((32'(grant_id) + 1) % N_REQ);
    end

    assign req_ready = grant_vec;
    assign rnd_ready = grant_found;

    // Count of valid tags currently in the pipeline.
    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i <= LAT; i++) begin
            inflight = inflight + INF_W'(tag_v[i]);
        end
    end

    // Gadget share/randomness registers: winner's data on issue, zero otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            g_a_0 <= '0;
            g_a_1 <= '0;
            g_b_0 <= '0;
            g_b_1 <= '0;
            g_r   <= '0;
        end else if (grant_found) begin
            g_a_0 <= a0_arr[grant_id];
            g_a_1 <= a1_arr[grant_id];
            g_b_0 <= b0_arr[grant_id];
            g_b_1 <= b1_arr[grant_id];
            g_r   <= rnd_data;
        end else begin
            g_a_0 <= '0;
            g_a_1 <= '0;
            g_b_0 <= '0;
            g_b_1 <= '0;
            g_r   <= '0;
        end
    end

    // Tag pipeline: LAT+1 stages, the last stage lines up with the gadget output.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_v <= '0;
            for (int unsigned i = 0; i <= LAT; i++) begin
                tag_id[i] <= '0;
            end
        end else begin
            tag_v[0]  <= grant_found;
            tag_id[0] <= grant_id;
            for (int unsigned i = 1; i <= LAT; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    // Response strobe vector for the op whose tag sits in the last stage.
    always_comb begin
        rsp_vec = '0;
        if (tag_v[LAT]) begin
            rsp_vec[tag_id[LAT]] = 1'b1;
        end
    end

    // Response register: forward gadget output only under a valid tag.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid <= '0;
            rsp_c_0   <= '0;
            rsp_c_1   <= '0;
        end else if (tag_v[LAT]) begin
            rsp_valid <= rsp_vec;
            rsp_c_0   <= g_c_0;
            rsp_c_1   <= g_c_1;
        end else begin
            rsp_valid <= '0;
            rsp_c_0   <= '0;
            rsp_c_1   <= '0;
        end
    end

    // Control FSM plus round-robin pointer and issued-op counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            ops_cnt <= '0;
        end else begin
            if (grant_found) begin
                ptr     <= ptr_nxt;
                ops_cnt <= ops_cnt + CNT_W'(1);
            end
            case (state)
                ST_IDLE: begin
                    if (en) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!en) begin
                        state <= (inflight != '0) ? ST_DRAIN : ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (en) begin
                        state <= ST_RUN;
                    end else if (inflight == '0) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

endmodule
